// File: rtl/rvfi_retire_sequencer.sv
// rvfi_retire_sequencer: serialises up to NRET RVFI retirements per cycle, in program order,
// into a FIFO and presents them one at a time to the ISS stepping logic.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rvfi_valid_i/order/pc/insn/trap  per-lane retirement inputs (lane k at [k*W +: W])
//   irq_i                       interrupt lines, snapshotted into every entry of a pushed group
//   step_valid_o/step_ready_i   head handshake; step_*_o carry the head entry
//   count_o                     FIFO occupancy
//   overflow_o                  sticky: a whole retirement group was dropped for lack of space
//   order_err_o                 sticky: an accepted entry broke the order+1 sequence
module rvfi_retire_sequencer #(
  parameter int unsigned NRET    = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ORDER_W = 64,
  parameter int unsigned IRQ_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NRET-1:0]            rvfi_valid_i,
  input  logic [NRET*ORDER_W-1:0]    rvfi_order_i,
  input  logic [NRET*XLEN-1:0]       rvfi_pc_i,
  input  logic [NRET*ILEN-1:0]       rvfi_insn_i,
  input  logic [NRET-1:0]            rvfi_trap_i,
  input  logic [IRQ_W-1:0]           irq_i,
  output logic                       step_valid_o,
  input  logic                       step_ready_i,
  output logic [XLEN-1:0]            step_pc_o,
  output logic [ILEN-1:0]            step_insn_o,
  output logic                       step_trap_o,
  output logic [ORDER_W-1:0]         step_order_o,
  output logic [IRQ_W-1:0]           step_irq_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       order_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  // Entry storage is not reset; outputs are masked while the FIFO is empty.
  logic [XLEN-1:0]    pc_q    [DEPTH];
  logic [XLEN-1:0]    pc_d    [DEPTH];
  logic [ILEN-1:0]    insn_q  [DEPTH];
  logic [ILEN-1:0]    insn_d  [DEPTH];
  logic               trap_q  [DEPTH];
  logic               trap_d  [DEPTH];
  logic [ORDER_W-1:0] order_q [DEPTH];
  logic [ORDER_W-1:0] order_d [DEPTH];
  logic [IRQ_W-1:0]   irq_q   [DEPTH];
  logic [IRQ_W-1:0]   irq_d   [DEPTH];

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               order_err_q, order_err_d;
  logic               first_q, first_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;

  logic [CW-1:0]      pcount;
  logic               accept;
  logic               pop;
  logic [PW-1:0]      n_written;
  logic [PW-1:0]      slot;
  logic [ORDER_W-1:0] lane_order;

  always_comb begin
    pcount = '0;
    for (int k = 0; k < NRET; k++) begin
      pcount = pcount + CW'(rvfi_valid_i[k]);
    end
    // Capacity uses the occupancy before any same-cycle pop.
    accept = (pcount <= (DepthC - count_q));
    pop    = (count_q != '0) && step_ready_i;
  end

  // Push path: compact valid lanes into consecutive slots and run the order check.
  always_comb begin
    pc_d        = pc_q;
    insn_d      = insn_q;
    trap_d      = trap_q;
    order_d     = order_q;
    irq_d       = irq_q;
    n_written   = '0;
    slot        = '0;
    lane_order  = '0;
    first_d     = first_q;
    exp_order_d = exp_order_q;
    order_err_d = order_err_q;

    if (accept) begin
      for (int k = 0; k < NRET; k++) begin
        if (rvfi_valid_i[k]) begin
          slot          = wr_ptr_q + n_written;
          lane_order    = rvfi_order_i[k*ORDER_W +: ORDER_W];
          pc_d[slot]    = rvfi_pc_i[k*XLEN +: XLEN];
          insn_d[slot]  = rvfi_insn_i[k*ILEN +: ILEN];
          trap_d[slot]  = rvfi_trap_i[k];
          order_d[slot] = lane_order;
          irq_d[slot]   = irq_i;
          if (first_d) begin
            first_d = 1'b0;
          end else if (lane_order != exp_order_d) begin
            order_err_d = 1'b1;
          end
          exp_order_d = lane_order + ORDER_W'(1);
          n_written   = n_written + PW'(1);
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + n_written;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + (accept ? pcount : '0) - CW'(pop);
    overflow_d = overflow_q | ~accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
      first_q     <= 1'b1;
      exp_order_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
      first_q     <= first_d;
      exp_order_q <= exp_order_d;
    end
  end

  // Storage only changes on accepted pushes; reset leaves it as-is since count gates the outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      trap_q  <= trap_d;
      order_q <= order_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    step_valid_o = (count_q != '0);
    step_pc_o    = step_valid_o ? pc_q[rd_ptr_q]    : '0;
    step_insn_o  = step_valid_o ? insn_q[rd_ptr_q]  : '0;
    step_trap_o  = step_valid_o ? trap_q[rd_ptr_q]  : 1'b0;
    step_order_o = step_valid_o ? order_q[rd_ptr_q] : '0;
    step_irq_o   = step_valid_o ? irq_q[rd_ptr_q]   : '0;
    count_o      = count_q;
    overflow_o   = overflow_q;
    order_err_o  = order_err_q;
  end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
module tb_rvfi_retire_sequencer;

  localparam int unsigned NRET  = 4;
  localparam int unsigned DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRET-1:0]      rvfi_valid_i;
  logic [NRET*64-1:0]   rvfi_order_i;
  logic [NRET*32-1:0]   rvfi_pc_i;
  logic [NRET*32-1:0]   rvfi_insn_i;
  logic [NRET-1:0]      rvfi_trap_i;
  logic [31:0]          irq_i;
  logic                 step_valid_o;
  logic                 step_ready_i;
  logic [31:0]          step_pc_o;
  logic [31:0]          step_insn_o;
  logic                 step_trap_o;
  logic [63:0]          step_order_o;
  logic [31:0]          step_irq_o;
  logic [3:0]           count_o;
  logic                 overflow_o;
  logic                 order_err_o;

  rvfi_retire_sequencer #(
    .NRET(NRET), .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .ORDER_W(64), .IRQ_W(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rvfi_valid_i (rvfi_valid_i),
    .rvfi_order_i (rvfi_order_i),
    .rvfi_pc_i    (rvfi_pc_i),
    .rvfi_insn_i  (rvfi_insn_i),
    .rvfi_trap_i  (rvfi_trap_i),
    .irq_i        (irq_i),
    .step_valid_o (step_valid_o),
    .step_ready_i (step_ready_i),
    .step_pc_o    (step_pc_o),
    .step_insn_o  (step_insn_o),
    .step_trap_o  (step_trap_o),
    .step_order_o (step_order_o),
    .step_irq_o   (step_irq_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .order_err_o  (order_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] irq;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one lane of the current group; accepted entries go to the scoreboard in lane order.
  task automatic set_lane(input int k, input logic [63:0] ord, input logic [31:0] pc,
                          input logic [31:0] insn, input logic trap, input bit acc);
    exp_t e;
    rvfi_valid_i[k]         = 1'b1;
    rvfi_order_i[k*64 +: 64] = ord;
    rvfi_pc_i[k*32 +: 32]    = pc;
    rvfi_insn_i[k*32 +: 32]  = insn;
    rvfi_trap_i[k]           = trap;
    if (acc) begin
      e.order = ord; e.pc = pc; e.insn = insn; e.trap = trap; e.irq = irq_i;
      sbq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rvfi_valid_i = '0;
    rvfi_trap_i  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!reset && step_valid_o && step_ready_i) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", {32'h0, step_pc_o}, 64'hdead_beef);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("step_order", step_order_o, e.order);
        check("step_pc", {32'h0, step_pc_o}, {32'h0, e.pc});
        check("step_insn", {32'h0, step_insn_o}, {32'h0, e.insn});
        check("step_trap", {63'h0, step_trap_o}, {63'h0, e.trap});
        check("step_irq", {32'h0, step_irq_o}, {32'h0, e.irq});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    rvfi_valid_i = '0;
    rvfi_order_i = '0;
    rvfi_pc_i    = '0;
    rvfi_insn_i  = '0;
    rvfi_trap_i  = '0;
    irq_i        = '0;
    step_ready_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_count", {60'h0, count_o}, 64'd0);
    check("rst_valid", {63'h0, step_valid_o}, 64'd0);
    check("rst_pc", {32'h0, step_pc_o}, 64'd0);
    check("rst_ovf", {63'h0, overflow_o}, 64'd0);
    check("rst_oerr", {63'h0, order_err_o}, 64'd0);

    // Single lane, one-cycle latency.
    step_ready_i = 1'b1;
    irq_i = 32'h0000_0080;
    set_lane(0, 64'd1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b1);
    tick();
    check("t1_valid", {63'h0, step_valid_o}, 64'd1);
    check("t1_count", {60'h0, count_o}, 64'd1);
    tick();
    check("t1_count_after_pop", {60'h0, count_o}, 64'd0);

    // Dual lane held, then drained.
    do_reset();
    step_ready_i = 1'b0;
    irq_i = 32'h0000_0800;
    set_lane(0, 64'd5, 32'h100, 32'h0010_0093, 1'b0, 1'b1);
    set_lane(1, 64'd6, 32'h104, 32'h0020_0113, 1'b1, 1'b1);
    tick();
    check("t2_count2", {60'h0, count_o}, 64'd2);
    check("t2_hold_pc", {32'h0, step_pc_o}, 64'h100);
    step_ready_i = 1'b1;
    tick();
    check("t2_count1", {60'h0, count_o}, 64'd1);
    tick();
    check("t2_count0", {60'h0, count_o}, 64'd0);
    check("t2_oerr", {63'h0, order_err_o}, 64'd0);

    // Sparse compaction: lanes 1 and 3.
    do_reset();
    irq_i = 32'h1234_5678;
    set_lane(1, 64'd10, 32'h200, 32'haaaa_0001, 1'b0, 1'b1);
    set_lane(3, 64'd11, 32'h204, 32'hbbbb_0002, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    check("t3_count0", {60'h0, count_o}, 64'd0);
    check("t3_oerr", {63'h0, order_err_o}, 64'd0);

    // Overflow: fill 8, drop a 2-entry group, drain exactly 8.
    do_reset();
    step_ready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      irq_i = 32'h100 + 32'(g);
      set_lane(0, 64'(20 + 2*g), 32'h1000 + 32'(8*g), 32'h0000_0013, 1'b0, 1'b1);
      set_lane(1, 64'(21 + 2*g), 32'h1004 + 32'(8*g), 32'h0000_0033, 1'b0, 1'b1);
      tick();
    end
    check("t4_full", {60'h0, count_o}, 64'd8);
    check("t4_no_ovf_yet", {63'h0, overflow_o}, 64'd0);
    set_lane(0, 64'd28, 32'h2000, 32'h1, 1'b0, 1'b0);
    set_lane(1, 64'd29, 32'h2004, 32'h2, 1'b0, 1'b0);
    tick();
    check("t4_ovf", {63'h0, overflow_o}, 64'd1);
    check("t4_count_kept", {60'h0, count_o}, 64'd8);
    step_ready_i = 1'b1;
    repeat (8) tick();
    check("t4_drained", {60'h0, count_o}, 64'd0);
    // Dropped group did not advance the expected order, so 30 is a gap.
    set_lane(0, 64'd30, 32'h3000, 32'h3, 1'b0, 1'b1);
    tick();
    check("t4_gap_after_ovf", {63'h0, order_err_o}, 64'd1);
    check("t4_ovf_sticky", {63'h0, overflow_o}, 64'd1);
    tick();

    // Order gap: 1 then 3.
    do_reset();
    set_lane(0, 64'd1, 32'h400, 32'h5, 1'b0, 1'b1);
    tick();
    check("t5_no_err", {63'h0, order_err_o}, 64'd0);
    set_lane(0, 64'd3, 32'h404, 32'h6, 1'b0, 1'b1);
    tick();
    check("t5_err", {63'h0, order_err_o}, 64'd1);
    tick();
    check("t5_count0", {60'h0, count_o}, 64'd0);

    // Reset mid-operation with order_err still set.
    step_ready_i = 1'b0;
    irq_i = 32'hffff_0000;
    set_lane(0, 64'd40, 32'h500, 32'h7, 1'b0, 1'b1);
    set_lane(1, 64'd41, 32'h504, 32'h8, 1'b0, 1'b1);
    set_lane(2, 64'd42, 32'h508, 32'h9, 1'b0, 1'b1);
    tick();
    check("t6_count3", {60'h0, count_o}, 64'd3);
    step_ready_i = 1'b1;
    set_lane(0, 64'd43, 32'h50c, 32'ha, 1'b0, 1'b1);
    tick();
    check("t6_push_pop", {60'h0, count_o}, 64'd3);
    do_reset();
    check("t6_rst_count", {60'h0, count_o}, 64'd0);
    check("t6_rst_valid", {63'h0, step_valid_o}, 64'd0);
    check("t6_rst_oerr", {63'h0, order_err_o}, 64'd0);
    check("t6_rst_ovf", {63'h0, overflow_o}, 64'd0);
    set_lane(0, 64'd42, 32'h600, 32'hb, 1'b0, 1'b1);
    tick();
    check("t6_valid", {63'h0, step_valid_o}, 64'd1);
    check("t6_no_err", {63'h0, order_err_o}, 64'd0);
    tick();
    check("t6_count0", {60'h0, count_o}, 64'd0);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_sequencer.md
Name: rvfi_retire_sequencer

Overview:
- Parametrised multi-retire front end for the reference model.
- Accepts up to NRET RVFI retirements per cycle from the DUT monitor and serialises them in program order into a FIFO.
- Presents them one at a time to the ISS stepping logic over a valid/ready handshake, with an interrupt snapshot taken at retirement.
- Flags FIFO overflow and RVFI order-number gaps.

Parameters:
- NRET, 2, number of retirement lanes per cycle (1..4).
- XLEN, 32, PC width.
- ILEN, 32, instruction word width.
- DEPTH, 8, FIFO entries (power of two, >= NRET).
- ORDER_W, 64, RVFI order field width.
- IRQ_W, 32, interrupt vector width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rvfi_valid_i  in  NRET  per-lane retirement valid.
- rvfi_order_i  in  NRET*ORDER_W  per-lane order number; lane k occupies bits [k*ORDER_W +: ORDER_W].
- rvfi_pc_i  in  NRET*XLEN  per-lane PC (rdata).
- rvfi_insn_i  in  NRET*ILEN  per-lane instruction word.
- rvfi_trap_i  in  NRET  per-lane trap flag.
- irq_i  in  IRQ_W  interrupt lines, sampled at push.
- step_valid_o  out  1  head entry available.
- step_ready_i  in  1  ISS consumes head.
- step_pc_o  out  XLEN  head PC.
- step_insn_o  out  ILEN  head instruction.
- step_trap_o  out  1  head trap flag.
- step_order_o  out  ORDER_W  head order.
- step_irq_o  out  IRQ_W  irq snapshot stored with the head entry.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky; a retirement group was dropped.
- order_err_o  out  1  sticky; order discontinuity seen.

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - Pointers, count and both sticky flags go to 0.
  - The "first" flag is set.
  - All step_*_o outputs are 0; count_o=0.
  - Reset overrides every simultaneous push and pop. Entries in flight are discarded with no partial output.
- Push:
  - Valid lanes are compacted in ascending lane index and written at consecutive FIFO slots starting at the write pointer.
  - Invalid lanes in between are skipped (e.g. valid=4'b1010 writes lane1 then lane3).
  - P = popcount(rvfi_valid_i).
- Capacity check:
  - The group is accepted only if P <= DEPTH - count, where count is taken before any same-cycle pop.
  - Otherwise the entire group is dropped (no partial writes) and overflow_o is set on the next cycle and held until reset.
- Pop: occurs when step_valid_o && step_ready_i. The read pointer advances by 1.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - count_next = count + P_accepted - pop.
- Pointers: wrap modulo DEPTH.
- Output timing:
  - Output is first-word-fall-through from registered storage.
  - An entry pushed at edge N is visible on step_*_o after edge N, i.e. one cycle of latency from rvfi_valid_i to step_valid_o.
  - step_valid_o = (count != 0).
  - step_*_o hold stable while step_valid_o=1 and step_ready_i=0.
  - When step_valid_o=0, data outputs are don't-care; the bench must not check them.
- IRQ snapshot: irq_i is registered into every entry of the accepted group on the push cycle.
- Order check (accepted groups only):
  - expected_order is held in a register.
  - For each accepted entry in lane order: if first=1, load expected_order = order+1 and clear first.
  - Otherwise, if order != expected_order, set order_err_o (sticky); in either case expected_order = order+1.
  - The entry is stored regardless of a mismatch.
  - Dropped groups do not update expected_order. The next accepted group is therefore checked against the last accepted order + 1, and a gap after overflow also raises order_err_o.
- Arithmetic: order increment wraps at 2^ORDER_W.

Test Plan:
- Single lane: lane0 valid with order=1, pc=0x80000000, insn=0x00000013, step_ready_i=1 -> step_valid_o=1 one cycle later with those values; count_o returns to 0 after the pop.
- Dual lane: valid=2'b11, orders 5/6, pcs 0x100/0x104, step_ready_i=0 -> count_o=2; then ready=1 -> head pc 0x100 then 0x104 on consecutive cycles; order_err_o=0.
- Sparse compaction with NRET=4: valid=4'b1010, orders 10/11 -> lane1 entry is output first, lane3 entry second.
- Overflow with DEPTH=8, ready=0: push 4 groups of 2 (count=8), then push 1 more -> group dropped, overflow_o=1, count_o=8. Drain -> exactly 8 pops, with order values matching the first 8 pushes.
- Order gap: push order 1, then order 3 -> order_err_o=1 the cycle after the second push; both entries are output.
- Reset mid-operation: count=3 with a concurrent push and pop, then assert reset for 1 cycle -> count_o=0, step_valid_o=0, flags=0. The next push of order=42 sets no order_err_o.
